// File: rtl/md_unit_ctrl.sv
// Multiply/divide controller for EX: owns HI/LO, runs a fixed busy window,
// and raises the stall request consumed by the hazard unit.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_D,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_stall
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  logic [3:0]  cnt;
  logic [31:0] a_q;
  logic [31:0] b_q;
  md_op_e      op_q;
  md_op_e      op_in;

  logic        is_md;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] dv_a;
  logic [31:0] dv_b;
  logic [31:0] dv_b_safe;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_we;

  assign op_in = md_op_e'(md_op);
  assign is_md = (md_op != 3'd0) && (md_op <= 3'd4);
  assign busy = (cnt != 4'd0);
  assign md_stall = md_use_D & (busy | (start & is_md));

  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide via magnitudes; this also yields 0x80000000 / -1 = 0x80000000.
  assign sgn = (op_q == OP_DIV);
  assign a_neg = sgn & a_q[31];
  assign b_neg = sgn & b_q[31];
  assign dv_a = a_neg ? (32'd0 - a_q) : a_q;
  assign dv_b = b_neg ? (32'd0 - b_q) : b_q;
  assign dv_b_safe = (dv_b == 32'd0) ? 32'd1 : dv_b;
  assign q_u = dv_a / dv_b_safe;
  assign r_u = dv_a % dv_b_safe;

  always_comb begin
    res_hi = hi;
    res_lo = lo;
    res_we = 1'b0;
    unique case (op_q)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
        res_we = 1'b1;
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
        res_we = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res_lo = (a_neg ^ b_neg) ? (32'd0 - q_u) : q_u;
        res_hi = a_neg ? (32'd0 - r_u) : r_u;
        res_we = (b_q != 32'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= 4'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      op_q <= OP_NONE;
      hi   <= 32'd0;
      lo   <= 32'd0;
    end else if (busy) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1 && res_we) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else if (start) begin
      unique case (op_in)
        OP_MULT, OP_MULTU: begin
          a_q  <= rs_val;
          b_q  <= rt_val;
          op_q <= op_in;
          cnt  <= 4'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          a_q  <= rs_val;
          b_q  <= rt_val;
          op_q <= op_in;
          cnt  <= 4'(DIV_CYCLES);
        end
        OP_MTHI: hi <= rs_val;
        OP_MTLO: lo <= rs_val;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Bench for md_unit_ctrl: directed scenarios plus random traffic,
// checked every cycle against a behavioural HI/LO model.
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  md_op = 3'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        md_use_D = 1'b0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        md_stall;

  int n_checks = 0;
  int n_fail = 0;
  bit started = 1'b0;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .md_use_D(md_use_D),
    .hi(hi), .lo(lo), .busy(busy), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  // Reference model: result computed at issue with wide integer arithmetic.
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          m_rem = 0;
  logic [31:0] m_rhi = 32'd0;
  logic [31:0] m_rlo = 32'd0;
  bit          m_rwe = 1'b0;

  function automatic logic [63:0] model_res(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    model_res = 64'd0;
    case (op)
      3'd1: begin p = sa * sb; model_res = p; end
      3'd2: begin up = ua * ub; model_res = up; end
      3'd3: begin
        q = sa / sb;
        r = sa % sb;
        model_res = {r[31:0], q[31:0]};
      end
      3'd4: begin
        up = ua / ub;
        model_res[31:0] = up[31:0];
        up = ua % ub;
        model_res[63:32] = up[31:0];
      end
      default: ;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi <= 32'd0;
      m_lo <= 32'd0;
      m_rem <= 0;
      m_rwe <= 1'b0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1 && m_rwe) begin
        m_hi <= m_rhi;
        m_lo <= m_rlo;
      end
    end else if (start) begin
      if (md_op >= 3'd1 && md_op <= 3'd4) begin
        logic [63:0] r;
        r = model_res(md_op, rs_val, rt_val);
        m_rhi <= r[63:32];
        m_rlo <= r[31:0];
        m_rwe <= (md_op <= 3'd2) || (rt_val != 32'd0);
        m_rem <= (md_op <= 3'd2) ? 5 : 10;
      end else if (md_op == 3'd5) begin
        m_hi <= rs_val;
      end else if (md_op == 3'd6) begin
        m_lo <= rs_val;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      logic exp_stall;
      exp_stall = md_use_D & ((m_rem != 0) |
                  (start & (md_op >= 3'd1) & (md_op <= 3'd4)));
      check("cyc_hi", hi, m_hi);
      check("cyc_lo", lo, m_lo);
      check("cyc_busy", {31'd0, busy}, {31'd0, m_rem != 0});
      check("cyc_stall", {31'd0, md_stall}, {31'd0, exp_stall});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    start = 1'b1;
    md_op = op;
    rs_val = a;
    rt_val = b;
    step(1);
    start = 1'b0;
    md_op = 3'd0;
  endtask

  initial begin
    int bcnt;
    @(posedge clk);
    #1;
    started = 1'b1;
    step(1);
    reset = 1'b0;
    md_use_D = 1'b1;
    step(3);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, md_stall}, 32'd0);

    // mult -2 * 3, stall raised in the start cycle itself
    start = 1'b1;
    md_op = 3'd1;
    rs_val = 32'hFFFF_FFFE;
    rt_val = 32'd3;
    #1;
    check("mult_start_stall", {31'd0, md_stall}, 32'd1);
    step(1);
    start = 1'b0;
    md_op = 3'd0;
    bcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    check("mult_busy_len", bcnt, 32'd5);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFA);
    check("mult_model_lo", m_lo, 32'hFFFF_FFFA);
    step(1);

    issue(3'd4, 32'd100, 32'd7);
    step(10);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    step(10);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_model_hi", m_hi, 32'hFFFF_FFFF);

    // divide by zero leaves HI/LO; starts mid-window are ignored
    issue(3'd5, 32'h11, 32'd0);
    issue(3'd6, 32'h22, 32'd0);
    issue(3'd3, 32'd5, 32'd0);
    step(3);
    issue(3'd1, 32'd2, 32'd3);
    issue(3'd5, 32'h99, 32'd0);
    step(5);
    check("dz_hi", hi, 32'h11);
    check("dz_lo", lo, 32'h22);
    check("dz_busy", {31'd0, busy}, 32'd0);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    step(10);
    check("ovf_lo", lo, 32'h8000_0000);
    check("ovf_hi", hi, 32'd0);

    // async reset in the middle of a multu window
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step(2);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", hi, 32'd0);
    check("arst_lo", lo, 32'd0);
    step(1);
    reset = 1'b0;
    step(1);
    issue(3'd2, 32'd2, 32'd3);
    step(5);
    check("multu_hi", hi, 32'd0);
    check("multu_lo", lo, 32'd6);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] b;
      start = ($urandom_range(0, 2) == 0);
      md_op = 3'($urandom_range(0, 7));
      rs_val = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        default: ;
      endcase
      rt_val = b;
      md_use_D = $urandom_range(0, 1) == 1;
      step(1);
    end
    start = 1'b0;
    step(12);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
